flash_loader: RTL and testbench

Boot-time copy engine that reads a contiguous image from the serial SPI flash and writes it into the burst RAM as 4-word (32-byte) write bursts. It is the initiator on both the flash SPI link and the burst RAM command port, and it runs before the core leaves reset. The core is held until `done` rises, so the core no longer needs its own flash-copy phase.

---
 rtl/flash_loader_pkg.sv | 32 +++
 rtl/flash_loader_spi_byte_shifter.sv | 52 +++++
 rtl/flash_loader.sv | 212 +++++++++++++++++++++
 tb/tb_flash_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: shared types and constants for the boot-time flash-to-RAM copy engine.
//   state_t      - copy engine states
//   FlashReadCmd - SPI flash sequential read opcode
//   BurstWords   - 64-bit words per burst RAM write burst
//   cmd_byte()   - byte n of the 4-byte read command (opcode + 24-bit address)
package flash_loader_pkg;

  typedef enum logic [2:0] {
    Idle,
    WaitRam,
    FlashCmd,
    FlashRead,
    RamWrite,
    RamGap,
    Verify
  } state_t;

  localparam logic [7:0]  FlashReadCmd = 8'h03;
  localparam int unsigned BurstWords   = 4;

  function automatic logic [7:0] cmd_byte(input logic [23:0] addr, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = FlashReadCmd;
      2'd1:    b = addr[23:16];
      2'd2:    b = addr[15:8];
      default: b = addr[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/flash_loader_spi_byte_shifter.sv
// spi_byte_shifter: mode-0 SPI byte engine, SCK = clk/2.
//   i_pause     - hold SCK low and freeze the shifter
//   i_load      - load i_tx_byte and restart the bit counter (SCK low)
//   i_miso      - sampled on the clk edge where SCK rises
//   o_sck/o_mosi- SPI clock and data out (MSB first)
//   o_byte_done - high in the cycle whose closing edge completes the 8th bit
//   o_rx_byte   - received byte, complete while o_byte_done is high
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pause,
  input  logic       i_load,
  input  logic [7:0] i_tx_byte,
  input  logic       i_miso,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_byte_done,
  output logic [7:0] o_rx_byte
);

  logic       r_phase;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_tx;
  logic [7:0] r_rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= 1'b0;
      r_bit_cnt <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
    end else if (i_load) begin
      r_tx      <= i_tx_byte;
      r_bit_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (!i_pause) begin
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_rx <= {r_rx[6:0], i_miso};
      end else begin
        r_tx      <= {r_tx[6:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  assign o_sck       = r_phase;
  assign o_mosi      = r_tx[7];
  assign o_byte_done = !i_pause && r_phase && (r_bit_cnt == 3'd7);
  assign o_rx_byte   = r_rx;

endmodule

// File: rtl/flash_loader.sv
// flash_loader: copies TransferBytes from SPI flash into burst RAM as 4-word write bursts.
//   start/busy/done/error          - control and sticky status
//   flash_clk/miso/mosi/cs         - SPI mode-0 initiator
//   br_*                           - burst RAM command port (word addressed, 64-bit data)
// Optional macro FLASH_LOADER_VERIFY_EN: read back every burst and flag mismatches on error.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int unsigned TransferBytes      = 4096,
  parameter logic [23:0] FlashStartAddress  = 24'h000000,
  parameter int unsigned RamAddressBitWidth = 11,
  parameter int unsigned RamStartAddress    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          flash_clk,
  input  logic                          flash_miso,
  output logic                          flash_mosi,
  output logic                          flash_cs,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RamAddressBitWidth-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid,
  input  logic                          br_init_calib,
  input  logic                          br_busy
);

  localparam int unsigned NumBursts = TransferBytes / 32;

  state_t                        r_state, w_next;
  logic [4:0]                    r_byte_idx;
  logic [1:0]                    r_word_idx;
  logic [31:0]                   r_burst_cnt;
  logic [255:0]                  r_buf;
  logic [RamAddressBitWidth-1:0] r_addr;
  logic                          r_busy, r_done, r_cs;
  logic                          w_load, w_pause, w_byte_done, w_burst_end, w_last_burst;
  logic [7:0]                    w_tx_byte, w_rx_byte;
  logic [63:0]                   w_word;
`ifdef FLASH_LOADER_VERIFY_EN
  logic                          r_rd_issued, r_error;
`else
  logic                          w_unused_rd;
  assign w_unused_rd = ^{br_rd_data, br_rd_data_valid};
`endif

  assign w_last_burst = (r_burst_cnt == 32'(NumBursts - 1));
  // flash byte n lands at bits [8n+7:8n] of the flat buffer, i.e. word n/8, little-endian
  assign w_word = r_buf[{r_word_idx, 6'b000000} +: 64];

  spi_byte_shifter u_spi (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_pause    (w_pause),
    .i_load     (w_load),
    .i_tx_byte  (w_tx_byte),
    .i_miso     (flash_miso),
    .o_sck      (flash_clk),
    .o_mosi     (flash_mosi),
    .o_byte_done(w_byte_done),
    .o_rx_byte  (w_rx_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= Idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_tx_byte   = '0;
    w_pause     = 1'b1;
    w_burst_end = 1'b0;
    br_cmd      = 1'b0;
    br_cmd_en   = 1'b0;
    br_wr_data  = '0;
    case (r_state)
      Idle:    if (start) w_next = WaitRam;
      WaitRam: begin
        if (br_init_calib && !br_busy) begin
          w_next    = FlashCmd;
          w_load    = 1'b1;
          w_tx_byte = FlashReadCmd;
        end
      end
      FlashCmd: begin
        w_pause = 1'b0;
        if (w_byte_done) begin
          w_load = 1'b1;
          if (r_byte_idx == 5'd3) w_next = FlashRead;
          else w_tx_byte = cmd_byte(FlashStartAddress, r_byte_idx[1:0] + 2'd1);
        end
      end
      FlashRead: begin
        w_pause = 1'b0;
        if (w_byte_done) begin
          w_load = 1'b1;
          if (r_byte_idx == 5'd31) w_next = RamWrite;
        end
      end
      RamWrite: begin
        br_cmd     = 1'b1;
        br_cmd_en  = (r_word_idx == 2'd0);
        br_wr_data = w_word;
        if (r_word_idx == 2'd3) w_next = RamGap;
      end
      RamGap: begin
        if (!br_busy) begin
`ifdef FLASH_LOADER_VERIFY_EN
          w_next = Verify;
`else
          w_burst_end = 1'b1;
          w_next      = w_last_burst ? Idle : FlashRead;
`endif
        end
      end
`ifdef FLASH_LOADER_VERIFY_EN
      Verify: begin
        br_cmd_en = !r_rd_issued;
        if (r_rd_issued && br_rd_data_valid && (r_word_idx == 2'd3)) begin
          w_burst_end = 1'b1;
          w_next      = w_last_burst ? Idle : FlashRead;
        end
      end
`endif
      default: w_next = Idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cs        <= 1'b1;
      r_addr      <= '0;
      r_burst_cnt <= '0;
      r_byte_idx  <= '0;
      r_word_idx  <= '0;
      r_buf       <= '0;
`ifdef FLASH_LOADER_VERIFY_EN
      r_rd_issued <= 1'b0;
      r_error     <= 1'b0;
`endif
    end else begin
      case (r_state)
        Idle: begin
          if (start) begin
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            r_addr      <= RamAddressBitWidth'(RamStartAddress);
            r_burst_cnt <= '0;
            r_byte_idx  <= '0;
            r_word_idx  <= '0;
`ifdef FLASH_LOADER_VERIFY_EN
            r_error     <= 1'b0;
`endif
          end
        end
        WaitRam:   if (w_next == FlashCmd) r_cs <= 1'b0;
        FlashCmd:  if (w_byte_done) r_byte_idx <= (r_byte_idx == 5'd3) ? 5'd0 : r_byte_idx + 5'd1;
        FlashRead: begin
          if (w_byte_done) begin
            r_buf[{r_byte_idx, 3'b000} +: 8] <= w_rx_byte;
            r_byte_idx                       <= r_byte_idx + 5'd1;
          end
        end
        RamWrite:  r_word_idx <= r_word_idx + 2'd1;
`ifdef FLASH_LOADER_VERIFY_EN
        Verify: begin
          if (!r_rd_issued) begin
            r_rd_issued <= 1'b1;
          end else if (br_rd_data_valid) begin
            if (br_rd_data != w_word) r_error <= 1'b1;
            r_word_idx <= r_word_idx + 2'd1;
            if (r_word_idx == 2'd3) r_rd_issued <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
      if (w_burst_end) begin
        r_addr      <= r_addr + RamAddressBitWidth'(BurstWords);
        r_burst_cnt <= r_burst_cnt + 32'd1;
        if (w_last_burst) begin
          r_cs   <= 1'b1;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign flash_cs     = r_cs;
  assign br_addr      = r_addr;
  assign br_data_mask = '0;
`ifdef FLASH_LOADER_VERIFY_EN
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: directed bench for flash_loader with a flash model (byte at address a = a[7:0]),
// a burst RAM model, and a cycle-level expectation of busy/done/flash_cs derived from the
// copy latency formula.
module tb_flash_loader;

  localparam int unsigned TB_BYTES = 64;
  localparam int unsigned TB_NB    = TB_BYTES / 32;
  localparam logic [23:0] TB_FLASH = 24'h000100;
  localparam int unsigned TB_AW    = 11;

  logic              clk = 1'b0;
  logic              rst_n, start;
  logic              busy, done, error;
  logic              flash_clk, flash_miso, flash_mosi, flash_cs;
  logic              br_cmd, br_cmd_en;
  logic [TB_AW-1:0]  br_addr;
  logic [63:0]       br_wr_data, br_rd_data;
  logic [7:0]        br_data_mask;
  logic              br_rd_data_valid, br_init_calib, br_busy;

  flash_loader #(
    .TransferBytes     (TB_BYTES),
    .FlashStartAddress (TB_FLASH),
    .RamAddressBitWidth(TB_AW),
    .RamStartAddress   (0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .flash_clk       (flash_clk),
    .flash_miso      (flash_miso),
    .flash_mosi      (flash_mosi),
    .flash_cs        (flash_cs),
    .br_cmd          (br_cmd),
    .br_cmd_en       (br_cmd_en),
    .br_addr         (br_addr),
    .br_wr_data      (br_wr_data),
    .br_data_mask    (br_data_mask),
    .br_rd_data      (br_rd_data),
    .br_rd_data_valid(br_rd_data_valid),
    .br_init_calib   (br_init_calib),
    .br_busy         (br_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // word idx of the image: flash bytes TB_FLASH + 8*idx .. +7, little-endian
  function automatic logic [63:0] model_word(input int unsigned idx);
    logic [63:0] w;
    logic [23:0] a;
    for (int unsigned j = 0; j < 8; j++) begin
      a = TB_FLASH + 24'(8 * idx + j);
      w[8*j +: 8] = a[7:0];
    end
    return w;
  endfunction

  // flash model: first 32 SCK rises clock in the command, later rises clock out data
  int unsigned sck_rises;
  logic [31:0] cmd_bits = '0;
  int unsigned fl_k;
  logic [23:0] fl_a;

  always @(posedge flash_clk or posedge flash_cs) begin
    if (flash_cs) begin
      sck_rises = 0;
    end else begin
      if (sck_rises < 32) cmd_bits = {cmd_bits[30:0], flash_mosi};
      sck_rises++;
    end
  end

  always @* begin
    flash_miso = 1'b0;
    fl_k = 0;
    fl_a = '0;
    if (sck_rises >= 32) begin
      fl_k = sck_rises - 32;
      fl_a = cmd_bits[23:0] + 24'(fl_k / 8);
      flash_miso = fl_a[7 - (fl_k % 8)];
    end
  end

  // RAM model and monitors
  logic [63:0] ram [0:2047];
  int cyc = 0;
  bit run_active = 0;
  int start_cyc, exp_len, cal_delay, k, done_k;
  int wr_left, wr_base, wr_burst, n_writes, n_reads, cs_falls, cs_rises;
  int exp_addr;
  bit prev_cmd_en, prev_cs, prev_done;
  int rd_left, rd_base;
  bit corrupt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      wr_left = 0; prev_cmd_en = 0; prev_cs = 1; prev_done = 0;
    end else begin
      if (run_active && cyc >= start_cyc) begin
        k = cyc - start_cyc;
        if (done && !prev_done) done_k = k;
`ifndef FLASH_LOADER_VERIFY_EN
        chk("busy", 64'(busy), 64'(k < exp_len));
        chk("done", 64'(done), 64'(k >= exp_len));
        chk("flash_cs", 64'(flash_cs), 64'(!(k >= 1 + cal_delay && k < exp_len)));
`endif
      end
      if (flash_cs != prev_cs) begin
        if (flash_cs) cs_rises++;
        else cs_falls++;
      end
      if (br_cmd_en) begin
        chk("cmd_en_width", 64'(prev_cmd_en), 64'd0);
        chk("data_mask", 64'(br_data_mask), 64'd0);
        if (br_cmd) begin
          chk("wr_addr", 64'(br_addr), 64'(exp_addr));
          wr_base  = int'(br_addr);
          wr_left  = 4;
          wr_burst = n_writes;
          n_writes++;
          exp_addr += 4;
        end else begin
          chk("rd_addr", 64'(br_addr), 64'(wr_base));
          n_reads++;
        end
      end
      if (wr_left > 0) begin
        chk("wr_data", br_wr_data, model_word(wr_burst * 4 + (4 - wr_left)));
        ram[wr_base + 4 - wr_left] = br_wr_data;
        wr_left--;
      end
      prev_cmd_en = br_cmd_en;
      prev_cs     = flash_cs;
      prev_done   = done;
    end
  end

  // read responder: 4 consecutive valid words starting the cycle after the read command
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_left = 0; br_rd_data_valid = 1'b0; br_rd_data = '0;
    end else begin
      if (rd_left > 0) begin
        br_rd_data_valid = 1'b1;
        br_rd_data = ram[rd_base + 4 - rd_left] ^
                     ((corrupt && (rd_base + 4 - rd_left) == 5) ? 64'h1 : 64'h0);
        rd_left--;
      end else begin
        br_rd_data_valid = 1'b0;
        br_rd_data = '0;
      end
      if (br_cmd_en && !br_cmd) begin
        rd_left = 4;
        rd_base = int'(br_addr);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_cs"},     64'(flash_cs),     64'd1);
    chk({tag, "_sck"},    64'(flash_clk),    64'd0);
    chk({tag, "_mosi"},   64'(flash_mosi),   64'd0);
    chk({tag, "_cmd_en"}, 64'(br_cmd_en),    64'd0);
    chk({tag, "_cmd"},    64'(br_cmd),       64'd0);
    chk({tag, "_addr"},   64'(br_addr),      64'd0);
    chk({tag, "_wdata"},  br_wr_data,        64'd0);
    chk({tag, "_mask"},   64'(br_data_mask), 64'd0);
    chk({tag, "_busy"},   64'(busy),         64'd0);
    chk({tag, "_done"},   64'(done),         64'd0);
    chk({tag, "_error"},  64'(error),        64'd0);
  endtask

  task automatic new_run(input int delay);
    run_active = 0;
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    exp_addr = 0; n_writes = 0; n_reads = 0; cs_falls = 0; cs_rises = 0;
    done_k = -1;
    cal_delay = delay;
    exp_len = 1 + delay + 64 + int'(TB_NB) * 517;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1; start_cyc = cyc + 1; run_active = 1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && !done; i++) @(posedge clk);
    #1 chk("done_seen", 64'(done), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_copy(input string tag);
    for (int unsigned i = 0; i < TB_NB * 4; i++) chk({tag, "_ram"}, ram[i], model_word(i));
    chk({tag, "_cmd"},      64'(cmd_bits), 64'h03000100);
    chk({tag, "_cs_falls"}, 64'(cs_falls), 64'd1);
    chk({tag, "_cs_rises"}, 64'(cs_rises), 64'd1);
    chk({tag, "_writes"},   64'(n_writes), 64'(TB_NB));
    chk({tag, "_busy_end"}, 64'(busy),     64'd0);
`ifdef FLASH_LOADER_VERIFY_EN
    chk({tag, "_reads"},    64'(n_reads),  64'(TB_NB));
`else
    chk({tag, "_reads"},    64'(n_reads),  64'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; br_init_calib = 1'b1; br_busy = 1'b0;
    #23 check_reset_values("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // A: plain copy, with an ignored start mid-copy
    new_run(0);
    pulse_start();
    repeat (300) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    check_copy("A");
    chk("A_word0", ram[0], 64'h0706050403020100);
    chk("A_word1", ram[1], 64'h0F0E0D0C0B0A0908);
    chk("A_word7", ram[7], 64'h3F3E3D3C3B3A3938);
    chk("A_error", 64'(error), 64'd0);
`ifndef FLASH_LOADER_VERIFY_EN
    chk("A_latency", 64'(done_k), 64'd1099);
`endif

    // B: calibration held low for 200 cycles; start also clears sticky done
    br_init_calib = 1'b0;
    new_run(200);
    pulse_start();
    chk("B_done_cleared", 64'(done), 64'd0);
    repeat (200) @(posedge clk);
    #1 br_init_calib = 1'b1;
    wait_done();
    check_copy("B");
`ifndef FLASH_LOADER_VERIFY_EN
    chk("B_latency", 64'(done_k), 64'd1299);
`endif

    // C: asynchronous reset in the middle of the flash read
    new_run(0);
    pulse_start();
    repeat (300) @(posedge clk);
    #2 chk("C_sck_high", 64'(flash_clk), 64'd1);
    chk("C_cs_low", 64'(flash_cs), 64'd0);
    run_active = 0;
    #1 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // D: copy restarts from the beginning after reset
    new_run(0);
    pulse_start();
    wait_done();
    check_copy("D");
    chk("D_word0", ram[0], 64'h0706050403020100);

    // E: RAM corrupts word 5 on readback
    corrupt = 1;
    new_run(0);
    pulse_start();
    wait_done();
    chk("E_done", 64'(done), 64'd1);
`ifdef FLASH_LOADER_VERIFY_EN
    chk("E_error", 64'(error), 64'd1);
`else
    chk("E_error", 64'(error), 64'd0);
`endif
    corrupt = 0;
    new_run(0);
    pulse_start();
    chk("F_error_cleared", 64'(error), 64'd0);
    wait_done();
    chk("F_error", 64'(error), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
